// File: rtl/riscv_soft_constants_pkg.sv
// Shared constants for the soft RISC-V tile: host op codes, access-size
// codes, control-register indices and access-size decode helpers.
package riscv_soft_constants;

  typedef enum logic [1:0] {
    HOST_OP_MEM_READ  = 2'd0,
    HOST_OP_MEM_WRITE = 2'd1,
    HOST_OP_REG_READ  = 2'd2,
    HOST_OP_REG_WRITE = 2'd3
  } host_op_e;

  localparam logic [2:0] MEM_TYPE_BYTE   = 3'd0;
  localparam logic [2:0] MEM_TYPE_HALF   = 3'd1;
  localparam logic [2:0] MEM_TYPE_WORD   = 3'd2;
  localparam logic [2:0] MEM_TYPE_BYTE_U = 3'd4;
  localparam logic [2:0] MEM_TYPE_HALF_U = 3'd5;

  localparam logic [1:0] REG_RUN      = 2'd0;
  localparam logic [1:0] REG_TOHOST   = 2'd1;
  localparam logic [1:0] REG_FROMHOST = 2'd2;
  localparam logic [1:0] REG_CYCLE    = 2'd3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_e;

  // Undefined size codes fall through to a full-word access.
  function automatic access_size_e access_size(input logic [2:0] op_type);
    case (op_type)
      MEM_TYPE_BYTE, MEM_TYPE_BYTE_U: return SZ_BYTE;
      MEM_TYPE_HALF, MEM_TYPE_HALF_U: return SZ_HALF;
      default:                        return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_signed_type(input logic [2:0] op_type);
    return (op_type == MEM_TYPE_BYTE) || (op_type == MEM_TYPE_HALF);
  endfunction

endpackage

// File: rtl/rv_soft_tile_mem.sv
// Single-port unified RAM with per-byte write enables and a registered read.
module rv_soft_tile_mem #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes and read-before-write word fetch on every enabled cycle.
  // NOTE: the array has no reset on purpose; clearing it would prevent RAM
  // inference and program images must survive a tile reset anyway.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rv_soft_tile.sv
// Tile memory/control shell: host port into a unified RAM and a small
// control-register block (RUN, TOHOST, FROMHOST, CYCLE). One-cycle latency.
module rv_soft_tile
  import riscv_soft_constants::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            host_req_ready,
  input  logic            host_req_valid,
  input  logic [1:0]      host_req_op,
  input  logic [2:0]      host_req_op_type,
  input  logic [XLEN-1:0] host_req_addr,
  input  logic [XLEN-1:0] host_req_data,
  output logic            host_resp_valid,
  output logic [XLEN-1:0] host_resp_data
);

  localparam int AW = $clog2(MEM_WORDS);

  host_op_e        req_op;
  access_size_e    req_size;
  logic            accept;
  logic            mem_en;
  logic [3:0]      mem_we;
  logic [AW-1:0]   mem_idx;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;

  logic            ready_q, ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            run_q, run_d;
  logic [XLEN-1:0] tohost_q, tohost_d;
  logic [XLEN-1:0] fromhost_q, fromhost_d;
  logic [XLEN-1:0] cycle_q, cycle_d;
  logic [XLEN-1:0] reg_rdata_q, reg_rdata_d;
  host_op_e        pend_op_q;
  access_size_e    pend_size_q;
  logic            pend_signed_q;
  logic [1:0]      pend_off_q;

  logic [31:0]     lane_shift;
  logic [XLEN-1:0] resp_data_c;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^host_req_addr[XLEN-1:AW+2];

  // Request decode: acceptance, RAM address, byte enables and lane-replicated write data.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    req_op    = host_op_e'(host_req_op);
    req_size  = access_size(host_req_op_type);
    accept    = host_req_valid && ready_q && !reset;
    mem_idx   = host_req_addr[AW+1:2];
    mem_en    = accept && (req_op == HOST_OP_MEM_READ || req_op == HOST_OP_MEM_WRITE);
    mem_we    = 4'b1111;
    mem_wdata = host_req_data;
    case (req_size)
      SZ_BYTE: begin
        mem_we    = 4'b0001 << host_req_addr[1:0];
        mem_wdata = {4{host_req_data[7:0]}};
      end
      SZ_HALF: begin
        mem_we    = host_req_addr[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{host_req_data[15:0]}};
      end
      default: ;
    endcase
    if (!(accept && req_op == HOST_OP_MEM_WRITE)) mem_we = 4'b0000;
  end

  rv_soft_tile_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Next-state for control registers, cycle counter and response handshake.
  always_comb begin
    ready_d      = 1'b1;
    resp_valid_d = accept;
    run_d        = run_q;
    tohost_d     = tohost_q;
    fromhost_d   = fromhost_q;
    cycle_d      = run_q ? cycle_q + XLEN'(1) : cycle_q;
    if (accept && req_op == HOST_OP_REG_WRITE) begin
      case (host_req_addr[1:0])
        REG_RUN:      run_d      = host_req_data[0];
        REG_TOHOST:   tohost_d   = host_req_data;
        REG_FROMHOST: fromhost_d = host_req_data;
        default:      ;
      endcase
    end
    case (host_req_addr[1:0])
      REG_RUN:      reg_rdata_d = {{(XLEN-1){1'b0}}, run_q};
      REG_TOHOST:   reg_rdata_d = tohost_q;
      REG_FROMHOST: reg_rdata_d = fromhost_q;
      default:      reg_rdata_d = cycle_q;
    endcase
  end

  // Response data: lane-select and extend RAM reads, pass register reads, zero for writes.
  always_comb begin
    lane_shift = (pend_size_q == SZ_HALF) ? mem_rdata >> {pend_off_q[1], 4'b0000}
                                          : mem_rdata >> {pend_off_q, 3'b000};
    resp_data_c = '0;
    case (pend_op_q)
      HOST_OP_MEM_READ: begin
        case (pend_size_q)
          SZ_BYTE: resp_data_c = pend_signed_q ? {{24{lane_shift[7]}}, lane_shift[7:0]}
                                               : {24'b0, lane_shift[7:0]};
          SZ_HALF: resp_data_c = pend_signed_q ? {{16{lane_shift[15]}}, lane_shift[15:0]}
                                               : {16'b0, lane_shift[15:0]};
          default: resp_data_c = mem_rdata;
        endcase
      end
      HOST_OP_REG_READ: resp_data_c = reg_rdata_q;
      default:          resp_data_c = '0;
    endcase
    hold_d = resp_valid_q ? resp_data_c : hold_q;
  end

  // Control state with synchronous reset; an in-flight response is dropped by reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      hold_q       <= '0;
      run_q        <= 1'b0;
      tohost_q     <= '0;
      fromhost_q   <= '0;
      cycle_q      <= '0;
    end else begin
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      hold_q       <= hold_d;
      run_q        <= run_d;
      tohost_q     <= tohost_d;
      fromhost_q   <= fromhost_d;
      cycle_q      <= cycle_d;
    end
  end

  // Per-request context captured at acceptance; only consumed alongside resp_valid_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_op_q     <= req_op;
      pend_size_q   <= req_size;
      pend_signed_q <= is_signed_type(host_req_op_type);
      pend_off_q    <= host_req_addr[1:0];
      reg_rdata_q   <= reg_rdata_d;
    end
  end

  assign host_req_ready  = ready_q;
  assign host_resp_valid = resp_valid_q && !reset;
  assign host_resp_data  = reset ? '0 : (resp_valid_q ? resp_data_c : hold_q);

endmodule

// File: tb/tb_rv_soft_tile.sv
// Scoreboard bench for rv_soft_tile: a byte-array/register reference model
// predicts every response at issue time; a monitor compares on each pulse.
module tb_rv_soft_tile;
  import riscv_soft_constants::*;

  localparam int MEM_WORDS = 1024;

  logic        clk;
  logic        reset;
  logic        host_req_ready;
  logic        host_req_valid;
  logic [1:0]  host_req_op;
  logic [2:0]  host_req_op_type;
  logic [31:0] host_req_addr;
  logic [31:0] host_req_data;
  logic        host_resp_valid;
  logic [31:0] host_resp_data;

  rv_soft_tile #(.MEM_WORDS(MEM_WORDS), .XLEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .host_req_ready   (host_req_ready),
    .host_req_valid   (host_req_valid),
    .host_req_op      (host_req_op),
    .host_req_op_type (host_req_op_type),
    .host_req_addr    (host_req_addr),
    .host_req_data    (host_req_data),
    .host_resp_valid  (host_resp_valid),
    .host_resp_data   (host_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    logic [31:0] data;
    int          edge_no;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state.
  logic [7:0]  mem_m [MEM_WORDS*4];
  logic        run_m;
  logic [31:0] tohost_m, fromhost_m, cyc_m;
  int          last_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int byte_base(input logic [31:0] addr);
    return ((addr >> 2) % MEM_WORDS) * 4;
  endfunction

  function automatic logic [31:0] model_mem_read(input logic [2:0] typ, input logic [31:0] addr);
    int base = byte_base(addr);
    logic [7:0]  b;
    logic [15:0] h;
    case (typ)
      3'd0, 3'd4: begin
        b = mem_m[base + int'(addr % 4)];
        return (typ == 3'd0) ? 32'($signed(b)) : {24'b0, b};
      end
      3'd1, 3'd5: begin
        h = {mem_m[base + int'(addr % 4) / 2 * 2 + 1], mem_m[base + int'(addr % 4) / 2 * 2]};
        return (typ == 3'd1) ? 32'($signed(h)) : {16'b0, h};
      end
      default: return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
    endcase
  endfunction

  task automatic model_mem_write(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] data);
    int base = byte_base(addr);
    int n;
    int first;
    case (typ)
      3'd0, 3'd4: begin n = 1; first = int'(addr % 4); end
      3'd1, 3'd5: begin n = 2; first = int'(addr % 4) / 2 * 2; end
      default:    begin n = 4; first = 0; end
    endcase
    for (int k = 0; k < n; k++) mem_m[base + first + k] = 8'(data >> (8 * k));
  endtask

  // Bring the cycle count up to the value visible just before edge e.
  task automatic advance(input int e);
    if (run_m) cyc_m += 32'(e - 1 - last_e);
    last_e = e - 1;
  endtask

  task automatic model_reset();
    run_m = 1'b0; tohost_m = '0; fromhost_m = '0; cyc_m = '0; last_e = edge_cnt;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] data, input string name);
    exp_t x;
    int   e;
    @(negedge clk);
    host_req_valid   = 1'b1;
    host_req_op      = op;
    host_req_op_type = typ;
    host_req_addr    = addr;
    host_req_data    = data;
    e         = edge_cnt + 1;
    x.edge_no = e;
    x.name    = name;
    x.data    = '0;
    case (op)
      2'd0: x.data = model_mem_read(typ, addr);
      2'd1: model_mem_write(typ, addr, data);
      2'd2: begin
        case (addr % 4)
          0: x.data = {31'b0, run_m};
          1: x.data = tohost_m;
          2: x.data = fromhost_m;
          default: begin advance(e); x.data = cyc_m; end
        endcase
      end
      default: begin
        case (addr % 4)
          0: begin advance(e); cyc_m += 32'(run_m); last_e = e; run_m = data[0]; end
          1: tohost_m = data;
          2: fromhost_m = data;
          default: ;
        endcase
      end
    endcase
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      host_req_valid = 1'b0;
    end
  endtask

  // Monitor: pop and compare each response pulse; between pulses data must hold.
  logic [31:0] last_resp = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (host_resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp: got data 0x%08h, expected no response", host_resp_data);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_timing"}, 32'(edge_cnt), 32'(e.edge_no));
          check(e.name, host_resp_data, e.data);
        end
        last_resp = host_resp_data;
      end else if (reset === 1'b1) begin
        last_resp = '0;
      end else begin
        check("hold", host_resp_data, last_resp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    reset = 1'b1; host_req_valid = 1'b0; host_req_op = '0; host_req_op_type = '0;
    host_req_addr = '0; host_req_data = '0;
    model_reset();

    // Reset held three cycles.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_ready", 32'(host_req_ready), 32'd0);
      check("rst_valid", 32'(host_resp_valid), 32'd0);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("ready_after_rst", 32'(host_req_ready), 32'd1);

    // Prefill the 16 words that later stimulus touches.
    for (int w = 0; w < 16; w++) issue(2'd1, MEM_TYPE_WORD, 32'(w * 4), $urandom, "prefill");

    // Directed memory cases.
    issue(2'd1, MEM_TYPE_WORD,   32'h10, 32'hDEADBEEF, "wr_word");
    issue(2'd0, MEM_TYPE_WORD,   32'h10, 32'h0, "rd_word");
    issue(2'd1, MEM_TYPE_BYTE,   32'h11, 32'h80, "wr_byte");
    issue(2'd0, MEM_TYPE_WORD,   32'h10, 32'h0, "rd_word_merged");
    issue(2'd0, MEM_TYPE_BYTE,   32'h11, 32'h0, "rd_byte_s");
    issue(2'd0, MEM_TYPE_BYTE_U, 32'h11, 32'h0, "rd_byte_u");
    issue(2'd0, MEM_TYPE_HALF,   32'h12, 32'h0, "rd_half_s");
    issue(2'd0, MEM_TYPE_HALF_U, 32'h12, 32'h0, "rd_half_u");
    issue(2'd0, MEM_TYPE_WORD,   32'h13, 32'h0, "rd_misaligned");
    issue(2'd0, 3'd6,            32'h10, 32'h0, "rd_undef_type");
    issue(2'd1, MEM_TYPE_WORD,   32'h1010, 32'h12345678, "wr_wrap");
    issue(2'd0, MEM_TYPE_WORD,   32'h10, 32'h0, "rd_wrap");
    idle(2);

    // Registers.
    issue(2'd3, MEM_TYPE_WORD, 32'd1, 32'hCAFEF00D, "wr_tohost");
    issue(2'd2, MEM_TYPE_WORD, 32'd1, 32'h0, "rd_tohost");
    issue(2'd3, MEM_TYPE_WORD, 32'd0, 32'd1, "wr_run");
    idle(9);
    issue(2'd2, MEM_TYPE_WORD, 32'd3, 32'h0, "rd_cycle");
    issue(2'd3, MEM_TYPE_WORD, 32'd3, 32'h0, "wr_cycle_ignored");
    issue(2'd2, MEM_TYPE_WORD, 32'd3, 32'h0, "rd_cycle_after_wr");
    issue(2'd2, MEM_TYPE_WORD, 32'd0, 32'h0, "rd_run");
    issue(2'd3, MEM_TYPE_WORD, 32'd0, 32'd0, "wr_run_off");
    idle(3);
    issue(2'd2, MEM_TYPE_WORD, 32'd3, 32'h0, "rd_cycle_stopped");

    // Back-to-back reads.
    issue(2'd0, MEM_TYPE_WORD, 32'h0, 32'h0, "b2b_0");
    issue(2'd0, MEM_TYPE_WORD, 32'h4, 32'h0, "b2b_4");
    issue(2'd0, MEM_TYPE_WORD, 32'h8, 32'h0, "b2b_8");
    idle(2);

    // Randomized mix over the prefilled region with aliased upper address bits.
    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = (op < 2) ? ($urandom & 32'hFFFF_F03F) : $urandom;
      issue(op, 3'($urandom_range(0, 7)), a, $urandom, "rand");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    // Reset with a read in flight: the response must be dropped.
    @(negedge clk);
    host_req_valid = 1'b1; host_req_op = 2'd0; host_req_op_type = MEM_TYPE_WORD;
    host_req_addr = 32'h0;
    @(posedge clk);
    #1 reset = 1'b1; host_req_valid = 1'b0;
    @(negedge clk);
    check("rst_drop_valid", 32'(host_resp_valid), 32'd0);
    // A write presented on a reset edge must be discarded.
    host_req_valid = 1'b1; host_req_op = 2'd1; host_req_op_type = MEM_TYPE_WORD;
    host_req_addr = 32'h20; host_req_data = ~model_mem_read(MEM_TYPE_WORD, 32'h20);
    @(negedge clk);
    host_req_valid = 1'b0;
    check("rst_ready_mid", 32'(host_req_ready), 32'd0);
    reset = 1'b0;
    model_reset();
    idle(1);
    issue(2'd0, MEM_TYPE_WORD, 32'h20, 32'h0, "rd_after_rst_write");
    issue(2'd2, MEM_TYPE_WORD, 32'd1, 32'h0, "rd_tohost_after_rst");
    issue(2'd2, MEM_TYPE_WORD, 32'd3, 32'h0, "rd_cycle_after_rst");
    idle(4);

    check("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
